// File: rtl/vx_onehot_stream_mux_pkg.sv
// Shared encodings for the stream multiplexer family.
package VX_gpu_pkg;

    localparam int unsigned MODE_ONEHOT   = 0;
    localparam int unsigned MODE_PRIORITY = 1;
    localparam int unsigned MODE_RR       = 2;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_onehot_stream_mux_skid_buffer.sv
// Two-entry registered skid buffer: ready_in depends only on occupancy
// and ready_out, so a full buffer still takes a beat on the cycle it drains.
module VX_skid_buffer #(
    parameter int unsigned DATAW = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_in,
    input  logic [DATAW-1:0] data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [DATAW-1:0] data_out,
    input  logic             ready_out
);

    logic [DATAW-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign valid_out = (count != 2'd0);
    assign data_out  = mem[rd_ptr];
    assign ready_in  = (count != 2'd2) || ready_out;
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;

    // Occupancy and pointers; reset drops any buffered beats.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; it is only read while valid_out is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/vx_onehot_stream_mux.sv
// N-to-1 stream multiplexer with one-hot, fixed-priority or round-robin
// arbitration and an optional registered output stage.
module vx_onehot_stream_mux
    import VX_gpu_pkg::*;
#(
    parameter int unsigned DATAW   = 1,
    parameter int unsigned N       = 2,
    parameter int unsigned MODE    = 0,
    parameter int unsigned OUT_REG = 1,
    localparam int unsigned SELW   = sel_width(N)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         valid_in,
    input  logic [N*DATAW-1:0]   data_in,
    output logic [N-1:0]         ready_in,
    input  logic [N-1:0]         sel_in,
    output logic                 valid_out,
    output logic [DATAW-1:0]     data_out,
    output logic [SELW-1:0]      sel_out,
    input  logic                 ready_out,
    output logic                 err_out
);

    if (N < 1 || N > 32) begin : g_bad_n
        $error("vx_onehot_stream_mux: N must be in 1..32");
    end
    if (MODE > MODE_RR) begin : g_bad_mode
        $error("vx_onehot_stream_mux: MODE must be 0, 1 or 2");
    end

    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [DATAW-1:0] grant_data;
    logic            sel_violation;
    logic            stage_ready;
    logic            fire;
    logic [SELW-1:0] rr_ptr;

    // Arbitration: pick one channel according to MODE.
    always_comb begin
        int unsigned idx;
        grant_valid   = 1'b0;
        grant_idx     = '0;
        sel_violation = 1'b0;
        idx           = 0;
        if (N == 1) begin
            grant_valid = valid_in[0];
        end else if (MODE == MODE_ONEHOT) begin
            sel_violation = (|valid_in) && ((sel_in & (sel_in - N'(1))) != '0);
            for (int unsigned i = 0; i < N; i++) begin
                if (!sel_violation && sel_in[i] && valid_in[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else if (MODE == MODE_PRIORITY) begin
            // Scan downwards so the lowest valid index is written last.
            for (int unsigned i = N; i > 0; i--) begin
                if (valid_in[i-1]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(i - 1);
                end
            end
        end else begin
            // Scan offsets downwards so the nearest one at/after rr_ptr wins.
            for (int unsigned i = N; i > 0; i--) begin
                idx = (32'(rr_ptr) + i - 1) % N;
                if (valid_in[idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = SELW'(idx);
                end
            end
        end
    end

    // Payload of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant_idx) == i) grant_data = data_in[i*DATAW +: DATAW];
        end
    end

    assign fire = grant_valid && stage_ready && resetn;

    // Only the granted channel sees ready, and only when its beat is taken.
    always_comb begin
        ready_in = '0;
        for (int unsigned i = 0; i < N; i++) begin
            ready_in[i] = fire && (32'(grant_idx) == i);
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [DATAW+SELW-1:0] buf_out;
        logic                  buf_ready;

        VX_skid_buffer #(
            .DATAW (DATAW + SELW)
        ) u_skid (
            .clk       (clk),
            .resetn    (resetn),
            .valid_in  (grant_valid),
            .data_in   ({grant_data, grant_idx}),
            .ready_in  (buf_ready),
            .valid_out (valid_out),
            .data_out  (buf_out),
            .ready_out (ready_out)
        );

        assign stage_ready         = buf_ready;
        assign {data_out, sel_out} = buf_out;
    end else begin : g_comb
        assign valid_out   = grant_valid && resetn;
        assign data_out    = grant_data;
        assign sel_out     = grant_idx;
        assign stage_ready = ready_out;
    end

    // Round-robin pointer moves past the channel that just transferred.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= '0;
        end else if (MODE == MODE_RR && N > 1 && fire) begin
            rr_ptr <= SELW'((32'(grant_idx) + 1) % N);
        end
    end

    // Sticky flag for multi-hot selects seen while any channel is valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_out <= 1'b0;
        end else if (sel_violation) begin
            err_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vx_onehot_stream_mux.sv
module tb_vx_onehot_stream_mux;

    logic clk;
    logic resetn;

    // one-hot select, registered
    logic [3:0]  oh_valid_in, oh_ready_in, oh_sel_in;
    logic [31:0] oh_data_in;
    logic        oh_valid_out, oh_ready_out, oh_err_out;
    logic [7:0]  oh_data_out;
    logic [1:0]  oh_sel_out;
    // round-robin, registered
    logic [3:0]  rr_valid_in, rr_ready_in, rr_sel_in;
    logic [31:0] rr_data_in;
    logic        rr_valid_out, rr_ready_out, rr_err_out;
    logic [7:0]  rr_data_out;
    logic [1:0]  rr_sel_out;
    // fixed priority, registered
    logic [3:0]  pr_valid_in, pr_ready_in, pr_sel_in;
    logic [31:0] pr_data_in;
    logic        pr_valid_out, pr_ready_out, pr_err_out;
    logic [7:0]  pr_data_out;
    logic [1:0]  pr_sel_out;
    // fixed priority, combinational
    logic [3:0]  cb_valid_in, cb_ready_in, cb_sel_in;
    logic [31:0] cb_data_in;
    logic        cb_valid_out, cb_ready_out, cb_err_out;
    logic [7:0]  cb_data_out;
    logic [1:0]  cb_sel_out;
    // single channel
    logic        on_valid_in, on_ready_in, on_sel_in;
    logic [7:0]  on_data_in, on_data_out;
    logic        on_valid_out, on_ready_out, on_err_out;
    logic        on_sel_out;

    int n_pass  = 0;
    int n_total = 0;

    vx_onehot_stream_mux #(.DATAW(8), .N(4), .MODE(0), .OUT_REG(1)) u_oh (
        .clk(clk), .resetn(resetn), .valid_in(oh_valid_in), .data_in(oh_data_in),
        .ready_in(oh_ready_in), .sel_in(oh_sel_in), .valid_out(oh_valid_out),
        .data_out(oh_data_out), .sel_out(oh_sel_out), .ready_out(oh_ready_out),
        .err_out(oh_err_out));

    vx_onehot_stream_mux #(.DATAW(8), .N(4), .MODE(2), .OUT_REG(1)) u_rr (
        .clk(clk), .resetn(resetn), .valid_in(rr_valid_in), .data_in(rr_data_in),
        .ready_in(rr_ready_in), .sel_in(rr_sel_in), .valid_out(rr_valid_out),
        .data_out(rr_data_out), .sel_out(rr_sel_out), .ready_out(rr_ready_out),
        .err_out(rr_err_out));

    vx_onehot_stream_mux #(.DATAW(8), .N(4), .MODE(1), .OUT_REG(1)) u_pr (
        .clk(clk), .resetn(resetn), .valid_in(pr_valid_in), .data_in(pr_data_in),
        .ready_in(pr_ready_in), .sel_in(pr_sel_in), .valid_out(pr_valid_out),
        .data_out(pr_data_out), .sel_out(pr_sel_out), .ready_out(pr_ready_out),
        .err_out(pr_err_out));

    vx_onehot_stream_mux #(.DATAW(8), .N(4), .MODE(1), .OUT_REG(0)) u_cb (
        .clk(clk), .resetn(resetn), .valid_in(cb_valid_in), .data_in(cb_data_in),
        .ready_in(cb_ready_in), .sel_in(cb_sel_in), .valid_out(cb_valid_out),
        .data_out(cb_data_out), .sel_out(cb_sel_out), .ready_out(cb_ready_out),
        .err_out(cb_err_out));

    vx_onehot_stream_mux #(.DATAW(8), .N(1), .MODE(0), .OUT_REG(0)) u_on (
        .clk(clk), .resetn(resetn), .valid_in(on_valid_in), .data_in(on_data_in),
        .ready_in(on_ready_in), .sel_in(on_sel_in), .valid_out(on_valid_out),
        .data_out(on_data_out), .sel_out(on_sel_out), .ready_out(on_ready_out),
        .err_out(on_err_out));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        oh_valid_in = '0; oh_sel_in = '0; oh_data_in = '0; oh_ready_out = 1'b0;
        rr_valid_in = '0; rr_sel_in = '0; rr_data_in = '0; rr_ready_out = 1'b0;
        pr_valid_in = '0; pr_sel_in = '0; pr_data_in = '0; pr_ready_out = 1'b0;
        cb_valid_in = '0; cb_sel_in = '0; cb_data_in = '0; cb_ready_out = 1'b0;
        on_valid_in = 1'b0; on_sel_in = 1'b0; on_data_in = '0; on_ready_out = 1'b0;
        tick();
        tick();
        check("rst_oh_valid", oh_valid_out, 0);
        check("rst_oh_err", oh_err_out, 0);
        check("rst_rr_valid", rr_valid_out, 0);
        check("rst_pr_valid", pr_valid_out, 0);
        resetn = 1'b1;
        tick();

        // one-hot select of channel 2
        oh_valid_in = 4'b1111; oh_sel_in = 4'b0100; oh_data_in = 32'h44A52211; oh_ready_out = 1'b1;
        #1;
        check("oh_ready_in", oh_ready_in, 4'b0100);
        tick();
        check("oh_valid", oh_valid_out, 1);
        check("oh_data", oh_data_out, 8'hA5);
        check("oh_sel", oh_sel_out, 2);
        oh_valid_in = '0; oh_sel_in = '0;
        tick();
        check("oh_drain", oh_valid_out, 0);

        // select pointing at a non-valid channel
        oh_valid_in = 4'b0010; oh_sel_in = 4'b0001;
        #1;
        check("oh_nosel_ready", oh_ready_in, 0);
        tick();
        check("oh_nosel_valid", oh_valid_out, 0);

        // multi-hot select
        oh_valid_in = 4'b0110; oh_sel_in = 4'b0110;
        #1;
        check("oh_viol_ready", oh_ready_in, 0);
        check("oh_err_pre", oh_err_out, 0);
        tick();
        check("oh_err_set", oh_err_out, 1);
        check("oh_viol_valid", oh_valid_out, 0);
        oh_valid_in = '0; oh_sel_in = '0;
        tick();
        check("oh_err_sticky", oh_err_out, 1);
        oh_valid_in = 4'b0001; oh_sel_in = 4'b0001;
        #1;
        check("oh_legal_ready", oh_ready_in, 4'b0001);
        tick();
        check("oh_legal_data", oh_data_out, 8'h11);
        check("oh_legal_valid", oh_valid_out, 1);
        check("oh_err_still", oh_err_out, 1);
        oh_valid_in = '0; oh_sel_in = '0;

        // round-robin with all channels valid
        rr_valid_in = 4'b1111; rr_data_in = 32'hD3D2D1D0; rr_ready_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_seq_sel", rr_sel_out, k % 4);
            check("rr_seq_data", rr_data_out, 8'hD0 + k % 4);
        end
        // sparse valids wrap past the end
        rr_valid_in = 4'b1010;
        tick();
        check("rr_wrap_a", rr_sel_out, 1);
        tick();
        check("rr_wrap_b", rr_sel_out, 3);
        tick();
        check("rr_wrap_c", rr_sel_out, 1);
        rr_valid_in = '0;
        tick();
        check("rr_idle_valid", rr_valid_out, 0);
        rr_valid_in = 4'b1111;
        tick();
        check("rr_hold_ptr", rr_sel_out, 2);
        rr_valid_in = '0;

        // fixed priority picks lowest valid index
        pr_ready_out = 1'b1; pr_valid_in = 4'b1110; pr_data_in = 32'hC3C2C1C0;
        tick();
        check("pr_sel", pr_sel_out, 1);
        check("pr_data", pr_data_out, 8'hC1);
        pr_valid_in = '0;
        tick();
        check("pr_drain", pr_valid_out, 0);

        // backpressure fills both entries then stalls
        pr_ready_out = 1'b0; pr_valid_in = 4'b0010; pr_data_in = 32'h0000B000;
        #1;
        check("bp_ready1", pr_ready_in, 4'b0010);
        tick();
        check("bp_data1", pr_data_out, 8'hB0);
        pr_data_in = 32'h0000B100;
        #1;
        check("bp_ready2", pr_ready_in, 4'b0010);
        tick();
        check("bp_data2", pr_data_out, 8'hB0);
        pr_data_in = 32'h0000B200;
        #1;
        check("bp_ready_full", pr_ready_in, 0);
        tick();
        check("bp_data3", pr_data_out, 8'hB0);
        check("bp_sel3", pr_sel_out, 1);
        check("bp_valid3", pr_valid_out, 1);
        pr_ready_out = 1'b1;
        #1;
        check("bp_ready_drain", pr_ready_in, 4'b0010);
        tick();
        check("bp_out_b1", pr_data_out, 8'hB1);
        pr_valid_in = '0;
        tick();
        check("bp_out_b2", pr_data_out, 8'hB2);
        tick();
        check("bp_empty", pr_valid_out, 0);

        // combinational output path
        cb_valid_in = 4'b0100; cb_data_in = 32'h00770000; cb_ready_out = 1'b0;
        #1;
        check("cb_valid", cb_valid_out, 1);
        check("cb_data", cb_data_out, 8'h77);
        check("cb_sel", cb_sel_out, 2);
        check("cb_ready_lo", cb_ready_in, 0);
        cb_ready_out = 1'b1;
        #1;
        check("cb_ready_hi", cb_ready_in, 4'b0100);
        cb_valid_in = 4'b0101; cb_data_in = 32'h00770055;
        #1;
        check("cb_sel_pri", cb_sel_out, 0);
        check("cb_data_pri", cb_data_out, 8'h55);
        cb_valid_in = '0;

        // single channel passes through
        on_valid_in = 1'b1; on_sel_in = 1'b0; on_data_in = 8'h3C; on_ready_out = 1'b1;
        #1;
        check("n1_valid", on_valid_out, 1);
        check("n1_data", on_data_out, 8'h3C);
        check("n1_sel", on_sel_out, 0);
        check("n1_ready", on_ready_in, 1);
        tick();
        check("n1_err", on_err_out, 0);

        // reset with a full buffer
        pr_ready_out = 1'b0; pr_valid_in = 4'b0010; pr_data_in = 32'h0000E000;
        tick();
        tick();
        check("rst_mid_full", pr_ready_in, 0);
        check("rst_mid_rrptr_pre", u_rr.rr_ptr, 3);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", pr_valid_out, 0);
        check("rst_mid_ready", pr_ready_in, 0);
        check("rst_mid_err", oh_err_out, 0);
        check("rst_mid_rrptr", u_rr.rr_ptr, 0);
        tick();
        pr_valid_in = '0; on_valid_in = 1'b0;
        resetn = 1'b1;
        tick();
        check("rst_discard", pr_valid_out, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
